// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet source.
// Sends cfg_count packets of cfg_len bytes each. Byte n of packet p carries
// (seed + p + n) mod 256. The configuration is captured on the start pulse.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [7:0]            cfg_seed,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tuser,
  output logic [ID_WIDTH-1:0]   m_tid,
  output logic [DEST_WIDTH-1:0] m_tdest
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Run state and latched configuration
  logic [1:0]            r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [7:0]            r_seed;
  logic [LEN_WIDTH-1:0]  r_lastBeat;
  logic [KEEP_WIDTH-1:0] r_lastKeep;
  logic [ID_WIDTH-1:0]   r_tid;
  logic [DEST_WIDTH-1:0] r_tdest;

  // Position of the beat currently presented, and the beat registers
  logic [LEN_WIDTH-1:0]  r_beat;
  logic [CNT_WIDTH-1:0]  r_pkt;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_tuser;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep;

  logic                  w_start;
  logic                  w_startEmpty;
  logic [LEN_WIDTH-1:0]  w_startLastBeat;
  logic [LEN_WIDTH-1:0]  w_startRem;
  logic [KEEP_WIDTH-1:0] w_startKeep;
  logic                  w_xfer;
  logic                  w_beatIsLast;
  logic                  w_pktIsLast;
  logic                  w_load;
  logic                  w_runEnd;
  logic [LEN_WIDTH-1:0]  w_nextBeat;
  logic [CNT_WIDTH-1:0]  w_nextPkt;
  logic [7:0]            w_selSeed;
  logic [LEN_WIDTH-1:0]  w_selLastBeat;
  logic [KEEP_WIDTH-1:0] w_selKeep;
  logic                  w_nextLast;
  logic                  w_nextFirst;
  logic [KEEP_WIDTH-1:0] w_nextKeep;
  logic [7:0]            w_beatOffset;
  logic [7:0]            w_base;
  logic [DATA_WIDTH-1:0] w_nextData;

  assign w_start         = (r_state == S_IDLE) && cfg_start;
  assign w_startEmpty    = (cfg_len == '0) || (cfg_count == '0);
  assign w_startLastBeat = (cfg_len - LEN_WIDTH'(1)) / LEN_WIDTH'(KEEP_WIDTH);
  assign w_startRem      = cfg_len % LEN_WIDTH'(KEEP_WIDTH);
  assign w_xfer          = r_tvalid && m_tready;
  assign w_beatIsLast    = (r_beat == r_lastBeat);
  assign w_pktIsLast     = (r_pkt == r_count - CNT_WIDTH'(1));

  // Final-beat keep mask: low (len mod lanes) bits, or every lane when it divides evenly
  always_comb begin
    w_startKeep = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      w_startKeep[b] = (w_startRem == '0) || (LEN_WIDTH'(b) < w_startRem);
    end
  end

  // Decide which beat goes on the bus next: first beat of a new run, the next
  // beat of this packet, the first beat of the next packet, or end of run
  always_comb begin
    w_load        = 1'b0;
    w_runEnd      = 1'b0;
    w_nextBeat    = r_beat;
    w_nextPkt     = r_pkt;
    w_selSeed     = r_seed;
    w_selLastBeat = r_lastBeat;
    w_selKeep     = r_lastKeep;
    if (w_start && !w_startEmpty) begin
      w_load        = 1'b1;
      w_nextBeat    = '0;
      w_nextPkt     = '0;
      w_selSeed     = cfg_seed;
      w_selLastBeat = w_startLastBeat;
      w_selKeep     = w_startKeep;
    end else if ((r_state == S_SEND) && w_xfer) begin
      if (w_beatIsLast) begin
        if (w_pktIsLast) begin
          w_runEnd = 1'b1;
        end else begin
          w_load     = 1'b1;
          w_nextBeat = '0;
          w_nextPkt  = r_pkt + CNT_WIDTH'(1);
        end
      end else begin
        w_load     = 1'b1;
        w_nextBeat = r_beat + LEN_WIDTH'(1);
      end
    end
  end

  // Build the payload of the selected beat; lanes past the packet end are zero
  always_comb begin
    w_nextLast   = (w_nextBeat == w_selLastBeat);
    w_nextFirst  = (w_nextBeat == '0);
    w_nextKeep   = w_nextLast ? w_selKeep : '1;
    w_beatOffset = 8'(32'(w_nextBeat) * 32'(KEEP_WIDTH));
    w_base       = w_selSeed + 8'(w_nextPkt) + w_beatOffset;
    w_nextData   = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      w_nextData[8*b +: 8] = w_nextKeep[b] ? (w_base + 8'(b)) : 8'h00;
    end
  end

  // Run control: capture configuration on start, then SEND -> FIN -> IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_seed     <= '0;
      r_lastBeat <= '0;
      r_lastKeep <= '0;
      r_tid      <= '0;
      r_tdest    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_count    <= cfg_count;
            r_seed     <= cfg_seed;
            r_lastBeat <= w_startLastBeat;
            r_lastKeep <= w_startKeep;
            r_tid      <= cfg_id;
            r_tdest    <= cfg_dest;
            if (w_startEmpty) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_SEND;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (w_runEnd) begin
            r_state <= S_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Beat registers: load a new beat when the previous one transfers, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_beat   <= '0;
      r_pkt    <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tlast  <= w_nextLast;
      r_tuser  <= w_nextFirst;
      r_tdata  <= w_nextData;
      r_tkeep  <= w_nextKeep;
      r_beat   <= w_nextBeat;
      r_pkt    <= w_nextPkt;
    end else if (w_runEnd) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_beat   <= '0;
      r_pkt    <= '0;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign m_tdata  = r_tdata;
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;
  assign m_tkeep  = r_tkeep;
  assign m_tuser  = r_tuser;
  assign m_tid    = r_tid;
  assign m_tdest  = r_tdest;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: randomized scoreboard bench for axis_pkt_gen.
// Expected beats come from a byte-level model of the packet pattern.
module tb_axis_pkt_gen;

  localparam int DW = 32;
  localparam int KW = DW / 8;
  localparam int LW = 16;
  localparam int CW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    logic          id;
    logic          dest;
    bit            runEnd;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfgStart;
  logic [LW-1:0] cfgLen;
  logic [CW-1:0] cfgCount;
  logic [7:0]    cfgSeed;
  logic          cfgId;
  logic          cfgDest;
  logic          busy;
  logic          mDone;
  logic [DW-1:0] mTdata;
  logic          mTvalid;
  logic          mTready;
  logic          mTlast;
  logic [KW-1:0] mTkeep;
  logic          mTuser;
  logic          mTid;
  logic          mTdest;

  int    testsRun    = 0;
  int    testsFailed = 0;
  int    cycle       = 0;
  int    doneDue     = -1;
  int    readyProb   = 100;
  bit    runDoneSeen = 0;
  bit    heldValid   = 0;
  logic [39:0] heldVec;
  logic [39:0] curVec;
  beat_t expQ[$];
  beat_t popped;

  axis_pkt_gen #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .LEN_WIDTH (LW),
    .CNT_WIDTH (CW),
    .ID_WIDTH  (1),
    .DEST_WIDTH(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfgStart),
    .cfg_len  (cfgLen),
    .cfg_count(cfgCount),
    .cfg_seed (cfgSeed),
    .cfg_id   (cfgId),
    .cfg_dest (cfgDest),
    .busy     (busy),
    .done     (mDone),
    .m_tdata  (mTdata),
    .m_tvalid (mTvalid),
    .m_tready (mTready),
    .m_tlast  (mTlast),
    .m_tkeep  (mTkeep),
    .m_tuser  (mTuser),
    .m_tid    (mTid),
    .m_tdest  (mTdest)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Downstream ready: asserted with probability readyProb percent each cycle
  always @(posedge clk) begin
    #1;
    mTready = ($urandom_range(0, 99) < readyProb);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Model: byte n of packet p is (seed + p + n) mod 256, packed lane 0 first
  task automatic pushExpected(input int len, input int cnt, input int seed, input int id, input int dest);
    int nb;
    beat_t bt;
    nb = (len + KW - 1) / KW;
    for (int p = 0; p < cnt; p++) begin
      for (int i = 0; i < nb; i++) begin
        bt.data = '0;
        bt.keep = '0;
        for (int b = 0; b < KW; b++) begin
          int n;
          n = i * KW + b;
          if (n < len) begin
            bt.data[8*b +: 8] = 8'((seed + p + n) % 256);
            bt.keep[b] = 1'b1;
          end
        end
        bt.last   = (i == nb - 1);
        bt.user   = (i == 0);
        bt.id     = id[0];
        bt.dest   = dest[0];
        bt.runEnd = (i == nb - 1) && (p == cnt - 1);
        expQ.push_back(bt);
      end
    end
  endtask

  task automatic issueStart(input int len, input int cnt, input int seed, input int id, input int dest);
    runDoneSeen = 0;
    @(posedge clk);
    #1;
    cfgLen   = LW'(len);
    cfgCount = CW'(cnt);
    cfgSeed  = 8'(seed);
    cfgId    = id[0];
    cfgDest  = dest[0];
    cfgStart = 1'b1;
    if (len == 0 || cnt == 0) doneDue = cycle + 1;
    @(posedge clk);
    #1;
    cfgStart = 1'b0;
    cfgLen   = LW'($urandom);
    cfgCount = CW'($urandom);
    cfgSeed  = 8'($urandom);
    cfgId    = 1'($urandom);
    cfgDest  = 1'($urandom);
  endtask

  task automatic applyStimulus(input int len, input int cnt, input int seed, input int id,
                               input int dest, input bit midStart);
    bit empty;
    empty = (len == 0 || cnt == 0);
    pushExpected(len, cnt, seed, id, dest);
    issueStart(len, cnt, seed, id, dest);
    @(negedge clk);
    checkOutput("startLatency", {62'd0, busy, mTvalid}, empty ? 64'd0 : 64'd3);
    if (midStart) begin
      @(posedge clk);
      #1;
      cfgLen   = LW'(len + 9);
      cfgStart = 1'b1;
      @(posedge clk);
      #1;
      cfgStart = 1'b0;
    end
    for (int c = 0; c < 20000 && !runDoneSeen; c++) @(negedge clk);
    if (!runDoneSeen) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL runTimeout actual=no done required=done (len %0d count %0d)", len, cnt);
    end
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    expQ.delete();
    doneDue = -1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pop and compare on every transfer, check hold stability while
  // stalled, and check the done pulse lands exactly one cycle after the run
  always @(negedge clk) begin
    curVec = {mTdata, mTkeep, mTlast, mTuser, mTid, mTdest};
    if (!rst) begin
      heldValid = 0;
    end else begin
      if (mTvalid) begin
        if (heldValid) checkOutput("holdStable", 64'(curVec), 64'(heldVec));
        if (mTready) begin
          if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpectedBeat actual=%h required=no beat", curVec);
          end else begin
            popped = expQ.pop_front();
            checkOutput("beat", 64'(curVec),
                        64'({popped.data, popped.keep, popped.last, popped.user, popped.id, popped.dest}));
            if (popped.runEnd) doneDue = cycle + 1;
          end
          heldValid = 0;
        end else begin
          heldVec   = curVec;
          heldValid = 1;
        end
      end else if (heldValid) begin
        checkOutput("validDropped", 64'(mTvalid), 64'd1);
        heldValid = 0;
      end
      if (mDone) begin
        checkOutput("doneTiming", 64'(cycle), 64'(doneDue));
        checkOutput("doneOutputs", {62'd0, mTvalid, busy}, 64'd0);
        runDoneSeen = 1;
        doneDue     = -1;
      end else if (doneDue == cycle) begin
        checkOutput("doneMissing", 64'(mDone), 64'd1);
        doneDue = -1;
      end
    end
  end

  initial begin
    rst      = 1'b0;
    cfgStart = 1'b0;
    cfgLen   = '0;
    cfgCount = '0;
    cfgSeed  = '0;
    cfgId    = 1'b0;
    cfgDest  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetBusy",  64'(busy),    64'd0);
    checkOutput("resetDone",  64'(mDone),   64'd0);
    checkOutput("resetValid", 64'(mTvalid), 64'd0);
    checkOutput("resetFlags", {62'd0, mTlast, mTuser}, 64'd0);
    checkOutput("resetData",  64'(mTdata),  64'd0);
    checkOutput("resetKeep",  64'(mTkeep),  64'd0);
    checkOutput("resetIdDst", {62'd0, mTid, mTdest}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Two back-to-back packets, full throughput
    readyProb = 100;
    applyStimulus(8, 2, 8'h10, 1, 0, 0);
    // Partial last beat with byte wrap
    applyStimulus(5, 1, 8'hFE, 0, 1, 0);
    // Single-beat packets under backpressure
    readyProb = 50;
    applyStimulus(3, 3, $urandom_range(0, 255), 1, 1, 0);
    // Empty runs
    readyProb = 100;
    applyStimulus(0, 5, 8'h22, 0, 0, 0);
    applyStimulus(7, 0, 8'h23, 1, 0, 0);
    // Start during a run is ignored
    applyStimulus(12, 3, 8'h40, 1, 1, 1);

    // Reset in the middle of a packet aborts without done
    pushExpected(16, 2, 8'h33, 1, 1);
    issueStart(16, 2, 8'h33, 1, 1);
    repeat (2) @(negedge clk);
    checkOutput("midResetPre", 64'(mTvalid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expQ.delete();
    doneDue = -1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midResetClear", {61'd0, mTvalid, busy, mDone}, 64'd0);
    repeat (4) @(negedge clk);
    applyStimulus(3, 1, 8'h77, 0, 1, 0);

    // Randomized runs with mixed backpressure
    for (int r = 0; r < 8; r++) begin
      readyProb = (r % 3 == 0) ? 100 : ((r % 3 == 1) ? 50 : 75);
      applyStimulus($urandom_range(1, 33), $urandom_range(1, 4), $urandom_range(0, 255),
                    $urandom_range(0, 1), $urandom_range(0, 1), 0);
    end

    // Largest legal packet count for the counter width
    readyProb = 100;
    applyStimulus(1, 255, 8'hA5, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
